lms_conv_mon: RTL and testbench

LMS_CONV_MON -- requirements
Module: lms_conv_mon

---
 rtl/lms_conv_mon_if.sv | 29 ++
 rtl/lms_conv_mon.sv | 186 ++++++++++++++++++
 tb/tb_lms_conv_mon.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms_conv_mon_if.sv
// lms_conv_mon_if -- bundle of the error-sample input and the convergence
// monitor outputs.
//   e_in/e_valid      : signed error sample and its qualifier (master -> slave)
//   mse_out/mse_valid : block mean-square error and its update pulse
//   state_out         : IDLE=0, ADAPT=1, CONV=2, DIV=3
//   converged/diverged: state decodes
//   blocks_out        : completed-block count, saturating at 255
interface lms_conv_mon_if #(
  parameter int W2 = 16
);
  logic signed [W2-1:0] e_in;
  logic                 e_valid;
  logic [W2-1:0]        mse_out;
  logic                 mse_valid;
  logic [1:0]           state_out;
  logic                 converged;
  logic                 diverged;
  logic [7:0]           blocks_out;

  modport master (
    output e_in, e_valid,
    input  mse_out, mse_valid, state_out, converged, diverged, blocks_out
  );

  modport slave (
    input  e_in, e_valid,
    output mse_out, mse_valid, state_out, converged, diverged, blocks_out
  );
endinterface

// File: rtl/lms_conv_mon.sv
// lms_conv_mon -- convergence monitor for a delayed-LMS filter.
// Squares each valid error sample, sums blocks of N = 2^LOG2N valid samples,
// publishes the scaled block MSE and classifies the filter as
// IDLE / ADAPT / CONV / DIV from successive block MSE values.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : lms_conv_mon_if slave (e_in/e_valid in; mse_out, mse_valid,
//           state_out, converged, diverged, blocks_out out)
module lms_conv_mon #(
  parameter int W2      = 16,
  parameter int LOG2N   = 4,
  parameter int SH      = 8,
  parameter int CONV_TH = 4,
  parameter int EXIT_TH = 16,
  parameter int DIV_TH  = 4096,
  parameter int HOLD    = 3
) (
  input logic          clk,
  input logic          reset,
  lms_conv_mon_if.slave bus
);

  localparam int AW = 2*W2 + LOG2N;   // accumulator width, holds N full-scale squares
  localparam int GW = $clog2(HOLD + 1);

  localparam logic [W2-1:0] CONV_T  = CONV_TH[W2-1:0];
  localparam logic [W2-1:0] EXIT_T  = EXIT_TH[W2-1:0];
  localparam logic [W2-1:0] DIV_T   = DIV_TH[W2-1:0];
  localparam logic [GW-1:0] HOLD_G  = GW'(HOLD);
  localparam logic [GW-1:0] HOLD_M1 = GW'(HOLD - 1);
  localparam logic [GW-1:0] ONE_G   = GW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADAPT = 2'd1,
    CONV  = 2'd2,
    DIV   = 2'd3
  } state_t;

  // Stage 1: input register
  logic signed [W2-1:0] s1_e_reg;
  logic                 s1_v_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_e_reg <= '0;
      s1_v_reg <= 1'b0;
    end else begin
      s1_e_reg <= bus.e_in;
      s1_v_reg <= bus.e_valid;
    end
  end

  // Stage 2: square (always non-negative, so the signed product fits unsigned)
  logic signed [2*W2-1:0] prod;
  logic [2*W2-1:0]        s2_sq_reg;
  logic                   s2_v_reg;

  assign prod = s1_e_reg * s1_e_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sq_reg <= '0;
      s2_v_reg  <= 1'b0;
    end else begin
      s2_sq_reg <= unsigned'(prod);
      s2_v_reg  <= s1_v_reg;
    end
  end

  // Stage 3: block accumulator. A zero sample count marks the first sample of
  // a block, which loads the accumulator so back-to-back blocks never mix.
  logic [AW-1:0]    acc_reg;
  logic [LOG2N-1:0] cnt_reg;
  logic             done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (s2_v_reg) begin
        if (cnt_reg == '0)
          acc_reg <= {{LOG2N{1'b0}}, s2_sq_reg};
        else
          acc_reg <= acc_reg + {{LOG2N{1'b0}}, s2_sq_reg};
        cnt_reg  <= cnt_reg + 1'b1;
        done_reg <= (cnt_reg == '1);
      end
    end
  end

  // Scaled block MSE, saturated to the output width
  logic [AW-1:0] acc_sh;
  logic [W2-1:0] mse_calc;

  assign acc_sh   = acc_reg >> (LOG2N + SH);
  assign mse_calc = (|acc_sh[AW-1:W2]) ? '1 : acc_sh[W2-1:0];

  // Output registers
  logic [W2-1:0] mse_reg;
  logic          mse_valid_reg;
  logic [7:0]    blocks_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mse_reg       <= '0;
      mse_valid_reg <= 1'b0;
      blocks_reg    <= '0;
    end else begin
      mse_valid_reg <= done_reg;
      if (done_reg) begin
        mse_reg <= mse_calc;
        if (blocks_reg != 8'hFF)
          blocks_reg <= blocks_reg + 8'd1;
      end
    end
  end

  // FSM: state register
  state_t        state_reg, state_next;
  logic [GW-1:0] good_reg, good_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      good_reg  <= '0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  // FSM: next state. Evaluated only when a block completes, i.e. in step
  // with the mse_out update; the divergence check overrides every state.
  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    if (done_reg) begin
      if (mse_calc >= DIV_T) begin
        state_next = DIV;
      end else begin
        case (state_reg)
          IDLE: begin
            state_next = ADAPT;
            good_next  = (mse_calc < CONV_T) ? ONE_G : '0;
          end
          ADAPT: begin
            if (mse_calc < CONV_T) begin
              if (good_reg >= HOLD_M1) begin
                state_next = CONV;
                good_next  = HOLD_G;
              end else begin
                good_next = good_reg + ONE_G;
              end
            end else begin
              good_next = '0;
            end
          end
          CONV: begin
            // Between CONV_TH and EXIT_TH the state holds (hysteresis)
            if (mse_calc >= EXIT_T) begin
              state_next = ADAPT;
              good_next  = '0;
            end
          end
          default: state_next = DIV;  // DIV is sticky
        endcase
      end
    end
  end

  // FSM: outputs
  always_comb begin
    bus.state_out  = state_reg;
    bus.converged  = (state_reg == CONV);
    bus.diverged   = (state_reg == DIV);
    bus.mse_out    = mse_reg;
    bus.mse_valid  = mse_valid_reg;
    bus.blocks_out = blocks_reg;
  end

endmodule

// File: tb/tb_lms_conv_mon.sv
// tb_lms_conv_mon -- scoreboard bench for lms_conv_mon.
// The driver feeds samples and a block-level reference model pushes one
// expected record per completed block; a negedge monitor pops a record on
// every mse_valid and compares value, state, block count and arrival edge.
module tb_lms_conv_mon;
  localparam int W2      = 16;
  localparam int LOG2N   = 4;
  localparam int N       = 1 << LOG2N;
  localparam int SH      = 8;
  localparam int CONV_TH = 4;
  localparam int EXIT_TH = 16;
  localparam int DIV_TH  = 4096;
  localparam int HOLD    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lms_conv_mon_if #(.W2(W2)) bus();

  lms_conv_mon #(
    .W2(W2), .LOG2N(LOG2N), .SH(SH), .CONV_TH(CONV_TH),
    .EXIT_TH(EXIT_TH), .DIV_TH(DIV_TH), .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     mse;
    int     st;
    int     blk;
    longint at;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain sum of squares over a block, then the
  // classification rules applied to the block's MSE.
  longint m_sum;
  int     m_cnt, m_state, m_good, m_blocks;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_sum = 0; m_cnt = 0; m_state = 0; m_good = 0; m_blocks = 0;
  endfunction

  function automatic void model_block(input longint at);
    longint mse;
    exp_t   e;
    mse = m_sum / (longint'(1) << (LOG2N + SH));
    if (mse > 65535) mse = 65535;
    if (m_state != 3) begin
      if (mse >= DIV_TH) m_state = 3;
      else if (m_state == 0) begin
        m_state = 1;
        m_good  = (mse < CONV_TH) ? 1 : 0;
      end else if (m_state == 1) begin
        if (mse < CONV_TH) begin
          m_good++;
          if (m_good >= HOLD) m_state = 2;
        end else m_good = 0;
      end else if (mse >= EXIT_TH) begin
        m_state = 1;
        m_good  = 0;
      end
    end
    if (m_blocks < 255) m_blocks++;
    e.mse = int'(mse); e.st = m_state; e.blk = m_blocks; e.at = at;
    sb.push_back(e);
  endfunction

  function automatic void model_accept(input int val, input longint edge_no);
    m_sum += longint'(val) * longint'(val);
    m_cnt++;
    if (m_cnt == N) begin
      model_block(edge_no + 3);
      m_sum = 0;
      m_cnt = 0;
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset && bus.mse_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mse_valid: got mse=%0d expected no pulse", bus.mse_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("block mse=%0d state=%0d blocks=%0d edge=%0d (exp mse=%0d state=%0d blocks=%0d edge=%0d)",
                 bus.mse_out, bus.state_out, bus.blocks_out, cyc, e.mse, e.st, e.blk, e.at);
        check("mse_out", bus.mse_out, e.mse);
        check("state_out", bus.state_out, e.st);
        check("converged", bus.converged, (e.st == 2) ? 1 : 0);
        check("diverged", bus.diverged, (e.st == 3) ? 1 : 0);
        check("blocks_out", bus.blocks_out, e.blk);
        check("latency_edge", cyc, e.at);
      end
    end
  end

  task automatic drive(input int val, input bit v);
    @(negedge clk);
    bus.e_in    = val[W2-1:0];
    bus.e_valid = v;
    if (v && !reset) model_accept(val, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0);
  endtask

  task automatic block(input int val, input bit gaps);
    int k;
    k = 0;
    while (k < N) begin
      if (gaps && $urandom_range(3) == 0) drive(val, 1'b0);
      else begin
        drive(val, 1'b1);
        k++;
      end
    end
  endtask

  task automatic block_rand(input int lo, input int hi);
    int k;
    int v;
    k = 0;
    while (k < N) begin
      v = int'($urandom_range(hi, lo));
      if ($urandom_range(1) == 1) v = -v;
      if ($urandom_range(3) == 0) drive(v, 1'b0);
      else begin
        drive(v, 1'b1);
        k++;
      end
    end
  endtask

  task automatic dut_now(input string tag, input int mse, input int st, input int blk);
    check({tag, "_mse"}, bus.mse_out, mse);
    check({tag, "_state"}, bus.state_out, st);
    check({tag, "_conv"}, bus.converged, (st == 2) ? 1 : 0);
    check({tag, "_div"}, bus.diverged, (st == 3) ? 1 : 0);
    check({tag, "_blocks"}, bus.blocks_out, blk);
  endtask

  // Reset with e_valid held high so reset must win over a valid sample
  task automatic do_reset(input bit drain);
    if (drain) idle(6);
    @(negedge clk);
    reset       = 1'b1;
    bus.e_in    = 16'sd16;
    bus.e_valid = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    dut_now("reset", 0, 0, 0);
    check("reset_mse_valid", bus.mse_valid, 0);
    reset       = 1'b0;
    bus.e_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.e_in    = '0;
    bus.e_valid = 1'b0;
    do_reset(1'b0);

    // Single block of 16 -> mse 1, ADAPT
    block(16, 1'b0);
    idle(5);
    dut_now("single16", 1, 1, 1);

    // Three zero blocks back to back -> CONV on the third
    do_reset(1'b1);
    repeat (3) block(0, 1'b0);
    idle(5);
    dut_now("zero3", 0, 2, 3);

    // Exit CONV via -128, then a quiet block gives good count 1;
    // two more quiet blocks reach HOLD
    block(-128, 1'b0);
    idle(5);
    dut_now("exit", 64, 1, 4);
    block(2, 1'b0);
    idle(5);
    dut_now("quiet", 0, 1, 5);
    block(0, 1'b0);
    block(0, 1'b0);
    idle(5);
    dut_now("reconv", 0, 2, 7);

    // Divergence is sticky
    block(1024, 1'b0);
    idle(5);
    dut_now("div", 4096, 3, 8);
    block(0, 1'b1);
    block(0, 1'b1);
    idle(5);
    dut_now("div_sticky", 0, 3, 10);

    // Saturation
    do_reset(1'b1);
    block(4096, 1'b0);
    idle(5);
    dut_now("sat", 65535, 3, 1);

    // Alternating valid: 32 cycles carry exactly 16 samples
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) drive(5, (i % 2) == 0);
    idle(5);
    dut_now("toggle", 0, 1, 1);

    // Reset mid-block discards the partial block
    do_reset(1'b1);
    repeat (10) drive(300, 1'b1);
    do_reset(1'b0);
    block(16, 1'b0);
    idle(5);
    dut_now("midreset", 1, 1, 1);

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(1'b1);
      for (int b = 0; b < 12; b++) begin
        int r;
        r = int'($urandom_range(19));
        if (r < 10)      block_rand(0, 8);
        else if (r < 18) block_rand(30, 100);
        else             block_rand(200, 2000);
      end
    end

    // Block counter saturation at 255
    do_reset(1'b1);
    repeat (260) block(0, 1'b0);
    idle(5);
    dut_now("blk_sat", 0, 2, 255);

    idle(6);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
